// File: rtl/enc8b10b_lanes.sv
// Multi-byte 8b/10b encoder (IEEE 802.3 Cl.36 code groups), 2-stage pipeline.
// Optional ENC_COMMA_FLAG_EN adds out_comma (K28.1/K28.5/K28.7 per slot).

module enc8b10b_lane (
    input  logic        din_k,
    input  logic [7:0]  din,
`ifdef ENC_COMMA_FLAG_EN
    output logic        comma,
`endif
    output logic [22:0] cand
);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] n6, c6_n, c6_p;
    logic [3:0] n4, c4_n, c4_p;
    logic       k_ok, k_err, flip6, flip4;

    always_comb begin
        k_ok  = (din[4:0] == 5'd28) || (din[7:5] == 3'd7 &&
                (din[4:0] == 5'd23 || din[4:0] == 5'd27 ||
                 din[4:0] == 5'd29 || din[4:0] == 5'd30));
        k_err = din_k && !k_ok;
        // an illegal control request is encoded as K28.5
        x = k_err ? 5'd28 : din[4:0];
        y = k_err ? 3'd5  : din[7:5];
        n6 = 6'b000000;
        case (x)
            5'd0:  n6 = 6'b100111;  5'd1:  n6 = 6'b011101;
            5'd2:  n6 = 6'b101101;  5'd3:  n6 = 6'b110001;
            5'd4:  n6 = 6'b110101;  5'd5:  n6 = 6'b101001;
            5'd6:  n6 = 6'b011001;  5'd7:  n6 = 6'b111000;
            5'd8:  n6 = 6'b111001;  5'd9:  n6 = 6'b100101;
            5'd10: n6 = 6'b010101;  5'd11: n6 = 6'b110100;
            5'd12: n6 = 6'b001101;  5'd13: n6 = 6'b101100;
            5'd14: n6 = 6'b011100;  5'd15: n6 = 6'b010111;
            5'd16: n6 = 6'b011011;  5'd17: n6 = 6'b100011;
            5'd18: n6 = 6'b010011;  5'd19: n6 = 6'b110010;
            5'd20: n6 = 6'b001011;  5'd21: n6 = 6'b101010;
            5'd22: n6 = 6'b011010;  5'd23: n6 = 6'b111010;
            5'd24: n6 = 6'b110011;  5'd25: n6 = 6'b100110;
            5'd26: n6 = 6'b010110;  5'd27: n6 = 6'b110110;
            5'd28: n6 = 6'b001110;  5'd29: n6 = 6'b101110;
            5'd30: n6 = 6'b011110;  5'd31: n6 = 6'b101011;
            default: n6 = 6'b000000;
        endcase
        if (din_k && x == 5'd28)
            n6 = 6'b001111;
        flip6 = ($countones(n6) != 3);
        c6_n  = n6;
        c6_p  = (flip6 || x == 5'd7) ? ~n6 : n6;

        n4 = 4'b0000;
        if (din_k) begin
            case (y)
                3'd0: n4 = 4'b1011;  3'd1: n4 = 4'b0110;
                3'd2: n4 = 4'b1010;  3'd3: n4 = 4'b1100;
                3'd4: n4 = 4'b1101;  3'd5: n4 = 4'b0101;
                3'd6: n4 = 4'b1001;  3'd7: n4 = 4'b0111;
                default: n4 = 4'b0000;
            endcase
            c4_n = n4;
            c4_p = ~n4;
        end else begin
            case (y)
                3'd0: n4 = 4'b1011;  3'd1: n4 = 4'b1001;
                3'd2: n4 = 4'b0101;  3'd3: n4 = 4'b1100;
                3'd4: n4 = 4'b1101;  3'd5: n4 = 4'b1010;
                3'd6: n4 = 4'b0110;  3'd7: n4 = 4'b1110;
                default: n4 = 4'b0000;
            endcase
            c4_n = n4;
            c4_p = (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6) ? n4 : ~n4;
            // A7 avoids a run of five equal bits across the 6b/4b boundary
            if (y == 3'd7) begin
                c4_n = (x == 5'd17 || x == 5'd18 || x == 5'd20) ? 4'b0111 : 4'b1110;
                c4_p = (x == 5'd11 || x == 5'd13 || x == 5'd14) ? 4'b1000 : 4'b0001;
            end
        end
        flip4 = (y == 3'd0 || y == 3'd4 || y == 3'd7);
    end

`ifdef ENC_COMMA_FLAG_EN
    assign comma = din_k && x == 5'd28 && (y == 3'd1 || y == 3'd5 || y == 3'd7);
`endif
    assign cand = {c6_n, c6_p, flip6, c4_n, c4_p, flip4, k_err};
endmodule

module enc8b10b_lanes #(
    parameter int NBYTES  = 2,
    parameter bit RD_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [8*NBYTES-1:0]  in_data,
    input  logic [NBYTES-1:0]    in_k,
    input  logic                 rd_load,
    input  logic                 rd_load_val,
    output logic                 out_valid,
    output logic [10*NBYTES-1:0] out_data,
    output logic                 out_rd,
`ifdef ENC_COMMA_FLAG_EN
    output logic [NBYTES-1:0]    code_err,
    output logic [NBYTES-1:0]    out_comma
`else
    output logic [NBYTES-1:0]    code_err
`endif
);
    typedef struct packed {
        logic [5:0] c6_n;
        logic [5:0] c6_p;
        logic       flip6;
        logic [3:0] c4_n;
        logic [3:0] c4_p;
        logic       flip4;
        logic       k_err;
    } lane_t;

    lane_t [NBYTES-1:0]   dec_w, s1_lane_d, s1_lane_q;
    logic                 s1_vld_d, s1_vld_q;
    logic                 out_valid_d, out_valid_q;
    logic [10*NBYTES-1:0] out_data_d, out_data_q, enc_data;
    logic [NBYTES-1:0]    code_err_d, code_err_q, enc_err;
    logic                 out_rd_d, out_rd_q, rd_d, rd_q;
    logic                 rd_start, rd_run;
    logic [5:0]           s6;
    logic [3:0]           s4;
`ifdef ENC_COMMA_FLAG_EN
    logic [NBYTES-1:0]    dec_comma_w, s1_comma_d, s1_comma_q, out_comma_d, out_comma_q;
`endif

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        enc8b10b_lane u_lane (
            .din_k (in_k[i]),
            .din   (in_data[8*i +: 8]),
`ifdef ENC_COMMA_FLAG_EN
            .comma (dec_comma_w[i]),
`endif
            .cand  (dec_w[i])
        );
    end

    always_comb begin
        s1_vld_d  = in_valid;
        s1_lane_d = in_valid ? dec_w : s1_lane_q;
`ifdef ENC_COMMA_FLAG_EN
        s1_comma_d = in_valid ? dec_comma_w : s1_comma_q;
`endif
        // RD ripples slot 0 -> NBYTES-1, 4b choice uses the RD after its own 6b
        rd_start = rd_load ? rd_load_val : rd_q;
        rd_run   = rd_start;
        enc_data = '0;
        enc_err  = '0;
        s6       = '0;
        s4       = '0;
        for (int i = 0; i < NBYTES; i++) begin
            s6     = rd_run ? s1_lane_q[i].c6_p : s1_lane_q[i].c6_n;
            rd_run = rd_run ^ s1_lane_q[i].flip6;
            s4     = rd_run ? s1_lane_q[i].c4_p : s1_lane_q[i].c4_n;
            rd_run = rd_run ^ s1_lane_q[i].flip4;
            enc_data[10*i +: 10] = {s6, s4};
            enc_err[i]           = s1_lane_q[i].k_err;
        end
        out_valid_d = s1_vld_q;
        out_data_d  = s1_vld_q ? enc_data : out_data_q;
        code_err_d  = s1_vld_q ? enc_err  : code_err_q;
        out_rd_d    = s1_vld_q ? rd_run   : out_rd_q;
        rd_d        = s1_vld_q ? rd_run   : rd_start;
`ifdef ENC_COMMA_FLAG_EN
        out_comma_d = s1_vld_q ? s1_comma_q : out_comma_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_lane_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            code_err_q  <= '0;
            out_rd_q    <= RD_INIT;
            rd_q        <= RD_INIT;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_lane_q   <= s1_lane_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            code_err_q  <= code_err_d;
            out_rd_q    <= out_rd_d;
            rd_q        <= rd_d;
        end
    end

`ifdef ENC_COMMA_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_comma_q  <= '0;
            out_comma_q <= '0;
        end else begin
            s1_comma_q  <= s1_comma_d;
            out_comma_q <= out_comma_d;
        end
    end
    assign out_comma = out_comma_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign code_err  = code_err_q;
    assign out_rd    = out_rd_q;
endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Scoreboard bench for enc8b10b_lanes: disparity-counting reference model.
module tb_enc8b10b_lanes;
    localparam int NB  = 2;
    localparam bit RDI = 1'b0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [8*NB-1:0]   in_data = '0;
    logic [NB-1:0]     in_k = '0;
    logic              rd_load = 1'b0;
    logic              rd_load_val = 1'b0;
    logic              out_valid;
    logic [10*NB-1:0]  out_data;
    logic              out_rd;
    logic [NB-1:0]     code_err;
`ifdef ENC_COMMA_FLAG_EN
    logic [NB-1:0]     out_comma;
`endif

    enc8b10b_lanes #(.NBYTES(NB), .RD_INIT(RDI)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_k        (in_k),
        .rd_load     (rd_load),
        .rd_load_val (rd_load_val),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_rd      (out_rd),
`ifdef ENC_COMMA_FLAG_EN
        .out_comma   (out_comma),
`endif
        .code_err    (code_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10*NB-1:0] data;
        logic             rd;
        logic [NB-1:0]    err;
        logic [NB-1:0]    comma;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // RD- forms of the 5b/6b and 3b/4b tables
    logic [5:0] d6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] d4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] k4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // A sub-block's disparity is read off its ones count; RD follows that.
    function automatic void ref_enc(input logic [7:0] b, input logic k, input logic rd_i,
                                    output logic [9:0] code, output logic rd_o,
                                    output logic err, output logic comma);
        int x, y;
        logic rd;
        logic [5:0] six;
        logic [3:0] four;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        err = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (err) begin x = 28; y = 5; end
        rd = rd_i;
        six = (k && x == 28) ? 6'b001111 : d6[x];
        if (rd && !($countones(six) == 3 && x != 7)) six = ~six;
        if ($countones(six) > 3) rd = 1'b1;
        else if ($countones(six) < 3) rd = 1'b0;
        if (k) four = rd ? ~k4[y] : k4[y];
        else if (y == 7) begin
            if (!rd) four = (x == 17 || x == 18 || x == 20) ? 4'b0111 : 4'b1110;
            else     four = (x == 11 || x == 13 || x == 14) ? 4'b1000 : 4'b0001;
        end else begin
            four = d4[y];
            if (rd && (y == 3 || $countones(four) != 2)) four = ~four;
        end
        if ($countones(four) > 2) rd = 1'b1;
        else if ($countones(four) < 2) rd = 1'b0;
        code  = {six, four};
        rd_o  = rd;
        comma = k && x == 28 && (y == 1 || y == 5 || y == 7);
    endfunction

    logic            m_rd = RDI;
    logic            m_prev_vld = 1'b0;
    logic [8*NB-1:0] m_prev_data = '0;
    logic [NB-1:0]   m_prev_k = '0;

    // Drive one cycle; the word issued last cycle sees this cycle's rd_load.
    task automatic drive(input logic v, input logic [8*NB-1:0] d, input logic [NB-1:0] k,
                         input logic ld, input logic ldv);
        exp_t e;
        logic r, rn, er, cm;
        logic [9:0] c;
        in_valid = v; in_data = d; in_k = k; rd_load = ld; rd_load_val = ldv;
        if (m_prev_vld) begin
            r = ld ? ldv : m_rd;
            for (int i = 0; i < NB; i++) begin
                ref_enc(m_prev_data[8*i +: 8], m_prev_k[i], r, c, rn, er, cm);
                e.data[10*i +: 10] = c;
                e.err[i] = er;
                e.comma[i] = cm;
                r = rn;
            end
            e.rd = r;
            m_rd = r;
            exp_q.push_back(e);
        end else if (ld) begin
            m_rd = ldv;
        end
        m_prev_vld = v; m_prev_data = d; m_prev_k = k;
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rand_byte(input logic k);
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (k && $urandom_range(0, 3) != 0) b = legal_k[$urandom_range(0, 11)];
        return b;
    endfunction

    task automatic drive_rand(input logic v);
        logic [8*NB-1:0] d;
        logic [NB-1:0]   k;
        for (int i = 0; i < NB; i++) begin
            k[i] = ($urandom_range(0, 5) == 0);
            d[8*i +: 8] = rand_byte(k[i]);
        end
        drive(v, d, k, $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: pops on out_valid, otherwise outputs must hold the last word.
    initial begin
        exp_t last, e;
        last.data = '0; last.rd = RDI; last.err = '0; last.comma = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last.data = '0; last.rd = RDI; last.err = '0; last.comma = '0;
            end else if (out_valid) begin
                check("word_expected", 80'(exp_q.size() != 0), 80'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 80'(out_data), 80'(e.data));
                    check("out_rd", 80'(out_rd), 80'(e.rd));
                    check("code_err", 80'(code_err), 80'(e.err));
`ifdef ENC_COMMA_FLAG_EN
                    check("out_comma", 80'(out_comma), 80'(e.comma));
`endif
                    last = e;
                end
            end else begin
                check("hold_data", 80'(out_data), 80'(last.data));
                check("hold_rd", 80'(out_rd), 80'(last.rd));
                check("hold_err", 80'(code_err), 80'(last.err));
            end
        end
    end

    initial begin
        logic [7:0] a_b [6] = '{8'hB5, 8'hBC, 8'hBC, 8'hF1, 8'hEB, 8'h00};
        logic       a_k [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       a_r [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0] a_c [6] = '{10'b1010101010, 10'b0011111010, 10'b1100000101,
                                10'b1000110111, 10'b1101001000, 10'b0011111010};
        logic       a_o [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [9:0] c;
        logic ro, er, cm;
        // anchor the reference model on known code groups
        for (int i = 0; i < 6; i++) begin
            ref_enc(a_b[i], a_k[i], a_r[i], c, ro, er, cm);
            check("model_code", 80'(c), 80'(a_c[i]));
            check("model_rd", 80'(ro), 80'(a_o[i]));
        end
        check("model_illegal_k_err", 80'(er), 80'd1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_valid", 80'(out_valid), 80'd0);
        check("rst_data", 80'(out_data), 80'd0);
        check("rst_rd", 80'(out_rd), 80'(RDI));
        check("rst_err", 80'(code_err), 80'd0);

        drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 16'hB5B5, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'hBCBC, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 16'hEBF1, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 16'h0000, 2'b11, 1'b1, 1'b1);
        drive(1'b1, 16'hFEF7, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 16'hE707, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 16'hB5EB, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);

        for (int n = 0; n < 10; n++) drive_rand(1'b1);
        for (int n = 0; n < 400; n++) drive_rand($urandom_range(0, 3) != 0);

        // reset mid-stream: in-flight words are discarded
        drive_rand(1'b1);
        drive_rand(1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        m_prev_vld = 1'b0;
        m_rd = RDI;
        in_valid = 1'b0; rd_load = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 80'(out_valid), 80'd0);
        check("midrst_rd", 80'(out_rd), 80'(RDI));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 80'(out_valid), 80'd0);

        for (int n = 0; n < 100; n++) drive_rand($urandom_range(0, 3) != 0);
        for (int n = 0; n < 4; n++) drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/enc8b10b_lanes.md
Name: enc8b10b_lanes

Overview:
Parametrised multi-byte 8b/10b encoder. It encodes NBYTES bytes per clock, data or control, into NBYTES 10-bit code groups using IEEE 802.3 Clause 36 tables. Running disparity (RD) is chained from byte to byte inside one word and carried across cycles. It sits between the framing/K-insertion logic and the serializer, and replaces the single-byte D-only encoder with a pipelined datapath that supports control characters.

Parameters:
NBYTES, 2, bytes encoded per clock (1..8); byte 0 is transmitted first.
RD_INIT, 0, RD value after reset (0 = RD-, 1 = RD+).

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  in_data/in_k qualify this cycle.
in_data  input  8*NBYTES  byte i at [8i+7:8i], bit 7 = H, bit 0 = A.
in_k  input  NBYTES  bit i set: byte i is a control character (K.x.y).
rd_load  input  1  force starting RD.
rd_load_val  input  1  RD value applied when rd_load = 1.
out_valid  output  1  out_data/out_rd/code_err qualify this cycle.
out_data  output  10*NBYTES  slot i at [10i+9:10i]; [10i+9:10i+4] = abcdei (a at MSB), [10i+3:10i] = fghj (f at MSB).
out_rd  output  1  RD after the last slot of the current output word.
code_err  output  NBYTES  bit i set: in_k[i] requested an illegal control code.

Behaviour:
- Reset values: out_valid = 0, out_data = 0, code_err = 0, out_rd = RD_INIT. The RD register is also set to RD_INIT. Both pipeline stages are flushed. Asserting reset mid-stream discards any word in flight.
- Pipeline, 2 stages, fixed latency 2 clocks from in_valid to out_valid. No backpressure; a word can be accepted every cycle.
- Stage 1 (registered): for each byte, decode the 5b/6b and 3b/4b candidate pairs (RD- and RD+ forms), their disparity class (0 or ±2), the alternate-7 selectors, and the K-legality check.
- Stage 2 (registered): serial RD chain across slots 0..NBYTES-1, using the standard 6b-then-4b rules:
  - A neutral 6b sub-block leaves RD unchanged, except D.07, which selects 111000 at RD- and 000111 at RD+. A ±2 sub-block flips RD.
  - The 4b sub-block is chosen with the RD that follows its own 6b sub-block. D.x.3 selects 1100 or 0011 without flipping RD.
  - D.x.7 uses the alternate form A7 in two cases:
    - RD- and x ∈ {17, 18, 20}, giving 0111.
    - RD+ and x ∈ {11, 13, 14}, giving 1000.
  - Otherwise D.x.7 uses P7.
- Legal K codes are K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7.
  - An illegal K code emits K28.5 at the current RD and sets code_err[i] for that word only.
  - The RD chain then continues as for K28.5.
- The RD register updates only when stage 2 holds a valid word. It loads the RD after slot NBYTES-1, and out_rd shows that same value.
- When stage 2 is empty, out_data, code_err and out_rd hold their last values and out_valid = 0.
- rd_load:
  - If stage 2 holds a valid word in the same cycle, rd_load_val replaces the RD register as the starting RD for that word's slot 0. The resulting end RD is then stored.
  - If stage 2 is empty, the RD register takes rd_load_val at the next edge.
  - rd_load takes priority over the normal update.

Optional Feature:
ENC_COMMA_FLAG_EN
- Defined: adds output out_comma [NBYTES-1:0], registered alongside out_data (latency 2, reset 0). Bit i is set when slot i is K28.1, K28.5 or K28.7, including an illegal K code replaced by K28.5.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset with RD_INIT = 0, then release -> out_valid = 0, out_data = 0, out_rd = 0. The first word below confirms RD-.
- NBYTES = 1, RD-: 0xB5 (D21.5), k = 0 -> two cycles later out_data = 10'b1010101010, out_rd = 0.
- NBYTES = 1, RD-: 0xBC with k = 1 (K28.5) -> 10'b0011111010, out_rd = 1. The next 0xBC -> 10'b1100000101, out_rd = 0.
- NBYTES = 2, RD-: byte0 = 0xBC (k = 1), byte1 = 0x00 (k = 0) -> slot0 = 0011111010, slot1 = 0110001011, out_rd = 1.
- NBYTES = 1, RD-: 0xF1 (D17.7) -> 1000110111 (A7), out_rd = 1. With rd_load = 1, rd_load_val = 1 then 0xEB (D11.7) -> 1101001000, out_rd = 0.
- NBYTES = 1: k = 1, data = 0x00 (illegal K), RD- -> 0011111010, code_err = 1, out_rd = 1. Back-to-back valid words for 10 cycles -> 10 contiguous out_valid, with RD chained correctly.
